// File: rtl/ntt_addrgen_param.sv
// ntt_addrgen_param: constant-geometry NTT/INTT address sequencer over four
// RAM banks arranged as two ping-pong pairs (P0 = banks 0/1, P1 = banks 2/3).
// Ports: clk, reset (async, active-low), start, valid, mode (0 NTT / 1 INTT);
//   i, j (butterfly index / stage), busy, done, out_sel (result pair);
//   ramN_ena/wea (write port), ramN_enb/web (read port, web held 0);
//   r_addr_0/1 (read addresses), w_addr_0/1 (write addresses), tw_addr.
// Optional: define ADDRGEN_BITREV_EN to bit-reverse final-stage write addresses.
module ntt_addrgen_param #(
    parameter int LOGN     = 8,
    parameter int ADDR_W   = LOGN - 1,
    parameter int STAGE_W  = 5,
    parameter int PIPE_LAT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               valid,
    input  logic               mode,
    output logic [ADDR_W-1:0]  i,
    output logic [STAGE_W-1:0] j,
    output logic               busy,
    output logic               done,
    output logic               out_sel,
    output logic               ram0_ena,
    output logic               ram1_ena,
    output logic               ram2_ena,
    output logic               ram3_ena,
    output logic               ram0_wea,
    output logic               ram1_wea,
    output logic               ram2_wea,
    output logic               ram3_wea,
    output logic               ram0_enb,
    output logic               ram1_enb,
    output logic               ram2_enb,
    output logic               ram3_enb,
    output logic               ram0_web,
    output logic               ram1_web,
    output logic               ram2_web,
    output logic               ram3_web,
    output logic [ADDR_W-1:0]  r_addr_0,
    output logic [ADDR_W-1:0]  r_addr_1,
    output logic [ADDR_W-1:0]  w_addr_0,
    output logic [ADDR_W-1:0]  w_addr_1,
    output logic [ADDR_W-1:0]  tw_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [STAGE_W-1:0] LAST      = STAGE_W'(LOGN - 1);
    localparam logic [ADDR_W-1:0]  I_MAX     = '1;
    localparam logic [3:0]         DRAIN_END = 4'(PIPE_LAT - 1);

    state_t               r_state;
    logic [ADDR_W-1:0]    r_i;
    logic [STAGE_W-1:0]   r_j;
    logic                 r_mode;
    logic                 r_src;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_out_sel;
    logic [3:0]           r_dcnt;

    logic [PIPE_LAT-1:0]             r_dl_fire;
    logic [PIPE_LAT-1:0]             r_dl_dst;
    logic [PIPE_LAT-1:0][ADDR_W-1:0] r_dl_i;

    logic                 w_fire;
    logic [STAGE_W-1:0]   w_s;
    logic                 w_last_stage;
    logic [ADDR_W-1:0]    w_tw_mask;
    logic                 w_wr;
    logic                 w_wdst;
    logic [ADDR_W-1:0]    w_wi;
    logic [ADDR_W-1:0]    w_waddr;

    assign w_fire       = (r_state == S_READ) && valid;
    // Stage ordinal: forward runs j upward, inverse runs it downward.
    assign w_s          = r_mode ? (LAST - r_j) : r_j;
    assign w_last_stage = (w_s == LAST);
    // Clears the low (LOGN-1-s) bits; a full-width shift yields zero.
    assign w_tw_mask    = {ADDR_W{1'b1}} << (LAST - w_s);

    assign w_wr   = r_dl_fire[PIPE_LAT-1];
    assign w_wdst = r_dl_dst[PIPE_LAT-1];
    assign w_wi   = r_dl_i[PIPE_LAT-1];

`ifdef ADDRGEN_BITREV_EN
    logic [ADDR_W-1:0] w_wi_rev;
    always_comb begin
        w_wi_rev = '0;
        for (int k = 0; k < ADDR_W; k++) begin
            w_wi_rev[k] = w_wi[ADDR_W-1-k];
        end
    end
    // Writes of the final stage complete before j moves on, so the
    // current stage ordinal identifies them.
    assign w_waddr = w_last_stage ? w_wi_rev : w_wi;
`else
    assign w_waddr = w_wi;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dl_fire <= '0;
            r_dl_dst  <= '0;
            r_dl_i    <= '0;
        end else begin
            for (int k = PIPE_LAT - 1; k > 0; k--) begin
                r_dl_fire[k] <= r_dl_fire[k-1];
                r_dl_dst[k]  <= r_dl_dst[k-1];
                r_dl_i[k]    <= r_dl_i[k-1];
            end
            r_dl_fire[0] <= w_fire;
            r_dl_dst[0]  <= ~r_src;
            r_dl_i[0]    <= r_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_mode    <= 1'b0;
            r_src     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_out_sel <= 1'b0;
            r_dcnt    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        r_mode  <= mode;
                        r_i     <= '0;
                        r_src   <= 1'b0;
                        r_j     <= mode ? LAST : '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (valid) begin
                        r_i <= r_i + ADDR_W'(1);
                        if (r_i == I_MAX) begin
                            r_state <= S_DRAIN;
                            r_dcnt  <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == DRAIN_END) begin
                        if (w_last_stage) begin
                            r_state   <= S_FIN;
                            r_done    <= 1'b1;
                            r_out_sel <= ~r_src;
                        end else begin
                            r_state <= S_READ;
                            r_src   <= ~r_src;
                            r_j     <= r_mode ? (r_j - STAGE_W'(1))
                                              : (r_j + STAGE_W'(1));
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 4'd1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i       = r_i;
    assign j       = r_j;
    assign busy    = r_busy;
    assign done    = r_done;
    assign out_sel = r_out_sel;

    assign ram0_enb = w_fire & ~r_src;
    assign ram1_enb = w_fire & ~r_src;
    assign ram2_enb = w_fire &  r_src;
    assign ram3_enb = w_fire &  r_src;
    assign ram0_web = 1'b0;
    assign ram1_web = 1'b0;
    assign ram2_web = 1'b0;
    assign ram3_web = 1'b0;

    assign ram0_ena = w_wr & ~w_wdst;
    assign ram1_ena = w_wr & ~w_wdst;
    assign ram2_ena = w_wr &  w_wdst;
    assign ram3_ena = w_wr &  w_wdst;
    assign ram0_wea = w_wr & ~w_wdst;
    assign ram1_wea = w_wr & ~w_wdst;
    assign ram2_wea = w_wr &  w_wdst;
    assign ram3_wea = w_wr &  w_wdst;

    assign r_addr_0 = r_i;
    assign r_addr_1 = r_i;
    assign w_addr_0 = w_waddr;
    assign w_addr_1 = w_waddr;
    assign tw_addr  = r_i & w_tw_mask;

endmodule

// File: doc/ntt_addrgen_param.md
Name: ntt_addrgen_param

Overview:
- Parametrised successor to the fixed-size NTT address generator.
- Sequences all LOGN radix-2 stages of a constant-geometry NTT/INTT over four single-word dual-port RAM banks, organised as two ping-pong pairs: pair P0 = banks 0/1, pair P1 = banks 2/3.
- Each cycle it issues one butterfly read address pair, a twiddle address, and a write address pair delayed by the butterfly pipeline latency.
- Inserts a drain gap between stages so read-after-write across stages is always safe.

Parameters:
- LOGN, 8: log2 of transform size N; one stage is N/2 butterflies.
- ADDR_W, LOGN-1: bank address width. Must equal LOGN-1.
- STAGE_W, 5: width of stage index j. Requires 2^STAGE_W > LOGN.
- PIPE_LAT, 4: butterfly latency in cycles from read issue to write issue. Legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a transform; sampled in IDLE only.
- valid  input  1  upstream data ready. Low stalls the read counter.
- mode  input  1  0 = forward NTT, 1 = inverse (stage order reversed). Latched at start.
- i  output  ADDR_W  current butterfly index within the stage.
- j  output  STAGE_W  current stage number.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the final write has been issued.
- out_sel  output  1  pair holding the result: 0 = P0, 1 = P1. Valid from done until the next start.
- ram0_ena..ram3_ena  output  1 each  port-A (write) enables.
- ram0_wea..ram3_wea  output  1 each  port-A write strobes.
- ram0_enb..ram3_enb  output  1 each  port-B (read) enables.
- ram0_web..ram3_web  output  1 each  port-B write strobes; held 0.
- r_addr_0, r_addr_1  output  ADDR_W each  read addresses for the lower and upper bank of the source pair.
- w_addr_0, w_addr_1  output  ADDR_W each  write addresses for the lower and upper bank of the destination pair.
- tw_addr  output  ADDR_W  twiddle ROM address.

Behaviour:
- Reset: all outputs 0. State = IDLE. Delay line cleared. Takes effect immediately, including mid-transform; no partial stage resumes afterwards.
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE:
  - start=1 -> READ.
  - Latch mode. Set i=0 and src=0 (P0 is the source of stage 0).
  - j = 0 if mode=0, else LOGN-1.
  - busy=1 from the next cycle.
- READ:
  - fire = valid. On a fire cycle, enb=1 on both source-pair banks; r_addr_0 = r_addr_1 = i.
  - tw_addr = i with its low (LOGN-1-s) bits cleared, where s is the stage ordinal 0..LOGN-1 (s = j for mode 0, LOGN-1-j for mode 1).
  - i increments on fire. valid=0 holds i; enb=0 and a bubble enters the delay line.
  - Fire with i = 2^ADDR_W-1 -> i wraps to 0, go to DRAIN.
- Delay line:
  - PIPE_LAT-deep shift of {fire, i, dst}.
  - At its output: ena=wea=1 on both banks of the destination pair; w_addr_0 = w_addr_1 = delayed i.
  - Writes are unaffected by valid.
- DRAIN:
  - Hold for exactly PIPE_LAT cycles after the last read fire, counted by a drain counter.
  - The last write is issued in the final DRAIN cycle.
  - If more stages remain: toggle src, step j (+1 for mode 0, -1 for mode 1), return to READ.
  - After the last stage -> FIN.
- FIN: done=1 for one cycle; out_sel = final destination pair; busy=0 from the next cycle; -> IDLE.
- Read and write pairs are never the same pair in any cycle.
- start while busy is ignored.
- valid may toggle arbitrarily; the total number of writes per stage is always exactly N/2.
- Arithmetic on i, j and the counters is unsigned with modular wrap at the declared widths.

Optional Feature:
- Macro ADDRGEN_BITREV_EN.
- Defined: during the final stage only, w_addr_0 and w_addr_1 are the ADDR_W-bit bit-reversal of the delayed i, so the result lands in natural order. All other stages are unchanged.
- Undefined: w_addr always equals the delayed i in every stage.

Test Plan:
- LOGN=4, PIPE_LAT=3, valid held 1, mode=0, start pulsed in cycle 0:
  - READ begins cycle 1; each stage takes 8 read + 3 drain = 11 cycles.
  - j goes 0,1,2,3; done at cycle 45; out_sel=0.
  - Exactly 32 writes, alternating P1, P0, P1, P0.
- Same configuration with mode=1:
  - j sequence 3,2,1,0.
  - Stage j=3 has tw_addr equal to i with its low 3 bits cleared (s=0, so tw_addr=0 for all i).
  - Cycle count identical to mode 0.
- valid dropped for 2 cycles at i=5 of stage 0:
  - i holds at 5 and enb=0 for those 2 cycles.
  - The matching write gap appears 3 cycles later; the stage still writes addresses 0..7 once each; done at cycle 47.
- Reset driven low at cycle 20 (mid stage 1):
  - All outputs are 0 asynchronously and state = IDLE.
  - After reset release, a new start gives the full 45-cycle run.
- start pulsed at cycle 10 while busy: ignored; schedule and done timing unchanged.
- ADDRGEN_BITREV_EN defined, LOGN=4: final-stage w_addr sequence is 0,4,2,6,1,5,3,7; earlier stages are sequential.
